// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce / edge-detect front end.
//
// Holds the FSM state encoding, the default parameter values used by
// debounce_edge_det, and the width of the optional glitch counter
// (enabled with DEBOUNCE_GLITCH_CNT_EN).
package debounce_pkg;

  // The low bit tracks "input currently seen high"; the high bit tracks the
  // committed output level. All four encodings are meaningful.
  typedef enum logic [1:0] {
    IDLE_LO = 2'b00,
    CHK_HI  = 2'b01,
    IDLE_HI = 2'b11,
    CHK_LO  = 2'b10
  } state_e;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_CNT_WIDTH     = 4;
  localparam int DEF_STABLE_CYCLES = 10;

  localparam int GLITCH_CNT_WIDTH  = 8;

endpackage

// File: rtl/debounce_edge_det_sync_chain.sv
// sync_chain: reset-to-0 shift chain used to bring an asynchronous input
// into the clk domain.
//
// Ports:
//   clk  - sampling clock
//   rstn - asynchronous active-low reset, clears every stage
//   d    - asynchronous input
//   q    - output of the last stage (synchronized)
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  always_comb begin
    chain_d = {chain_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/debounce_edge_det.sv
// debounce_edge_det: synchronizes a raw bouncy input, qualifies it with a
// stability counter and produces a clean level plus one-cycle edge pulses.
//
// Ports:
//   clk        - system clock
//   rstn       - asynchronous active-low reset
//   din        - raw asynchronous input (may bounce)
//   dout       - debounced level (registered)
//   rise       - one-cycle pulse when dout goes 0->1 (registered)
//   fall       - one-cycle pulse when dout goes 1->0 (registered)
//   glitch_cnt - saturating count of aborted checks; present only when
//                DEBOUNCE_GLITCH_CNT_EN is defined
module debounce_edge_det
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int CNT_WIDTH     = DEF_CNT_WIDTH,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic dout,
  output logic rise,
`ifdef DEBOUNCE_GLITCH_CNT_EN
  output logic fall,
  output logic [GLITCH_CNT_WIDTH-1:0] glitch_cnt
`else
  output logic fall
`endif
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic s;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  dout_q, dout_d;
  logic                  rise_q, rise_d;
  logic                  fall_q, fall_d;

  sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rstn(rstn),
    .d   (din),
    .q   (s)
  );

  // With a single required cycle the check state would add a cycle of
  // latency, so the idle states commit directly instead.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      IDLE_LO: begin
        cnt_d  = '0;
        dout_d = 1'b0;
        if (s) begin
          if (STABLE_CYCLES == 1) begin
            state_d = IDLE_HI;
            dout_d  = 1'b1;
            rise_d  = 1'b1;
          end else begin
            state_d = CHK_HI;
            cnt_d   = CNT_ONE;
          end
        end
      end
      CHK_HI: begin
        if (!s) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HI;
          dout_d  = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE_HI: begin
        cnt_d  = '0;
        dout_d = 1'b1;
        if (!s) begin
          if (STABLE_CYCLES == 1) begin
            state_d = IDLE_LO;
            dout_d  = 1'b0;
            fall_d  = 1'b1;
          end else begin
            state_d = CHK_LO;
            cnt_d   = CNT_ONE;
          end
        end
      end
      CHK_LO: begin
        if (s) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LO;
          dout_d  = 1'b0;
          fall_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE_LO;
        cnt_d   = '0;
        dout_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE_LO;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign dout = dout_q;
  assign rise = rise_q;
  assign fall = fall_q;

`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic                        abort;
  logic [GLITCH_CNT_WIDTH-1:0] glitch_cnt_q, glitch_cnt_d;

  // An abort is a check state seeing the synchronized input fall back to
  // the committed level before qualification completes.
  always_comb begin
    abort        = ((state_q == CHK_HI) && !s) || ((state_q == CHK_LO) && s);
    glitch_cnt_d = glitch_cnt_q;
    if (abort && (glitch_cnt_q != '1)) begin
      glitch_cnt_d = glitch_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      glitch_cnt_q <= '0;
    end else begin
      glitch_cnt_q <= glitch_cnt_d;
    end
  end

  assign glitch_cnt = glitch_cnt_q;
`endif

endmodule
